// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding-select and load-use hazard control for the
// RV32 5-stage pipeline. Tracks the destination tags of the instructions
// in EX, MEM and WB. It produces registered 2-bit select codes for the two
// EX operand muxes, and combinational stall/bubble strobes.
//
// Optional build macro HAZ_PERF_CNT_EN adds the stall_cnt and flush_cnt
// performance counters. Forwarding and stall behaviour do not depend on it.
//
// Select encoding: 00 regfile, 01 WB data, 10 EX/MEM ALU result (11 unused).
// slot_dbg exposes {wb, mem, ex} slots; each slot is {valid, rd, regwrite, memread}.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter bit X0_FWD_BLOCK = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [REG_ADDR_W-1:0]         id_rs1,
  input  logic [REG_ADDR_W-1:0]         id_rs2,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_regwrite,
  input  logic                          id_memread,
  input  logic                          flush_ex,
  output logic [1:0]                    fwd_a_sel,
  output logic [1:0]                    fwd_b_sel,
  output logic                          stall_if_id,
  output logic                          bubble_ex,
  output logic [3*(REG_ADDR_W+3)-1:0]   slot_dbg
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   flush_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } slot_t;

  slot_t      ex_q, mem_q, wb_q;
  slot_t      ex_d;
  logic       load_use;
  logic       stall;
  logic [1:0] next_a_sel, next_b_sel;

  // A destination of x0 is invisible to forwarding and stalling when blocking is on.
  function automatic logic rd_blocked(input logic [REG_ADDR_W-1:0] rd);
    return X0_FWD_BLOCK && (rd == '0);
  endfunction

  // Select for one operand. The newest producer (the slot now in EX, which
  // is bound for MEM) wins. A load in EX is never forwarded from EX.
  function automatic logic [1:0] sel_for(input logic [REG_ADDR_W-1:0] rs,
                                         input slot_t ex_s,
                                         input slot_t mem_s);
    if (ex_s.valid && ex_s.regwrite && !ex_s.memread &&
        (rs == ex_s.rd) && !rd_blocked(ex_s.rd))
      return 2'b10;
    else if (mem_s.valid && mem_s.regwrite &&
             (rs == mem_s.rd) && !rd_blocked(mem_s.rd))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Hazard detection, next EX slot contents and next select codes.
  always_comb begin
    load_use   = 1'b0;
    stall      = 1'b0;
    ex_d       = '0;
    next_a_sel = 2'b00;
    next_b_sel = 2'b00;

    // Reset discards any pending hazard, so no stall is visible while rst_n is low.
    load_use = rst_n && id_valid && ex_q.valid && ex_q.memread && ex_q.regwrite &&
               !rd_blocked(ex_q.rd) &&
               ((id_rs1 == ex_q.rd) || (id_rs2 == ex_q.rd));
    // A flush kills the consumer anyway, so it overrides the stall.
    stall = load_use && !flush_ex;

    ex_d.valid    = id_valid && !load_use && !flush_ex;
    ex_d.rd       = id_rd;
    ex_d.regwrite = id_regwrite;
    ex_d.memread  = id_memread;

    if (ex_d.valid) begin
      next_a_sel = sel_for(id_rs1, ex_q, mem_q);
      next_b_sel = sel_for(id_rs2, ex_q, mem_q);
    end
  end

  // Shadow pipeline: the slots advance on every edge. EX takes the decode
  // fields, or a bubble on a hazard or flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  // The select registers line up with the instruction during its EX cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else begin
      fwd_a_sel <= next_a_sel;
      fwd_b_sel <= next_b_sel;
    end
  end

  assign stall_if_id = stall;
  assign bubble_ex   = stall;
  assign slot_dbg    = {wb_q, mem_q, ex_q};

`ifdef HAZ_PERF_CNT_EN
  // Free-running event counters that wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)    stall_cnt <= stall_cnt + 32'd1;
      if (flush_ex) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed vectors run on two instances. blk has x0
// blocking on; nb treats x0 as an ordinary register. Each step drives one
// decode cycle and pushes the outputs expected in that cycle. The monitor
// pops these and compares them at the falling edge.
module tb_fwd_hazard_ctrl;

  localparam int W  = 5;
  localparam int SW = 3 * (W + 3);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         id_valid, id_regwrite, id_memread, flush_ex;
  logic [W-1:0] id_rs1, id_rs2, id_rd;

  logic [1:0]    blk_a, blk_b, nb_a, nb_b;
  logic          blk_stall, blk_bub, nb_stall, nb_bub;
  logic [SW-1:0] blk_slot, nb_slot;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   blk_scnt, blk_fcnt, nb_scnt, nb_fcnt;
`endif

  fwd_hazard_ctrl #(.REG_ADDR_W(W), .X0_FWD_BLOCK(1'b1)) u_blk (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush_ex(flush_ex),
    .fwd_a_sel(blk_a), .fwd_b_sel(blk_b), .stall_if_id(blk_stall), .bubble_ex(blk_bub),
    .slot_dbg(blk_slot)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(blk_scnt), .flush_cnt(blk_fcnt)
`endif
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(W), .X0_FWD_BLOCK(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush_ex(flush_ex),
    .fwd_a_sel(nb_a), .fwd_b_sel(nb_b), .stall_if_id(nb_stall), .bubble_ex(nb_bub),
    .slot_dbg(nb_slot)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(nb_scnt), .flush_cnt(nb_fcnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  string       name_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  initial begin
    logic [11:0] e;
    logic [5:0]  got;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {blk_a, blk_b, blk_stall, blk_bub};
        n_chk++;
        if (got !== e[11:6]) begin
          n_fail++;
          $display("FAIL %s blk: got a=%b b=%b stall=%b bubble=%b, expected a=%b b=%b stall=%b bubble=%b",
                   nm, got[5:4], got[3:2], got[1], got[0], e[11:10], e[9:8], e[7], e[6]);
        end
        got = {nb_a, nb_b, nb_stall, nb_bub};
        n_chk++;
        if (got !== e[5:0]) begin
          n_fail++;
          $display("FAIL %s nb: got a=%b b=%b stall=%b bubble=%b, expected a=%b b=%b stall=%b bubble=%b",
                   nm, got[5:4], got[3:2], got[1], got[0], e[5:4], e[3:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // The step drives one decode cycle. ea/eb/es are the expected outputs for blk
  // in this cycle, and na/nb/ns those for nb. The selects belong to the
  // instruction that decoded one step earlier.
  task automatic step(input logic v, input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                      input logic [W-1:0] rd, input logic rw, input logic mr,
                      input logic fl, input logic rn,
                      input logic [1:0] ea, input logic [1:0] eb, input logic es,
                      input logic [1:0] na, input logic [1:0] nb, input logic ns,
                      input bit chk, input string nm);
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_regwrite = rw; id_memread = mr; flush_ex = fl; rst_n = rn;
    if (chk) begin
      exp_q.push_back({ea, eb, es, es, na, nb, ns, ns});
      name_q.push_back(nm);
    end
  endtask

  task automatic idle(input logic [1:0] ea, input logic [1:0] eb,
                      input logic [1:0] na, input logic [1:0] nb, input string nm);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, ea, eb, 1'b0, na, nb, 1'b0, 1'b1, nm);
  endtask

  // A producer or consumer that does not stall, and whose previous-decode selects are 00.
  task automatic instr(input logic [W-1:0] rs1, input logic [W-1:0] rs2, input logic [W-1:0] rd,
                       input logic rw, input logic mr, input string nm);
    step(1'b1, rs1, rs2, rd, rw, mr, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, nm);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_regwrite = 1'b0; id_memread = 1'b0; flush_ex = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "reset");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "post_reset");

    // EX->EX: add x5,x1,x2 ; sub x6,x5,x7
    instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, "add_x5");
    instr(5'd5, 5'd7, 5'd6, 1'b1, 1'b0, "sub_issue");
    idle(2'b10, 2'b00, 2'b10, 2'b00, "ex_ex");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");

    // MEM->EX: add x5 ; nop ; or x8,x5,x5
    instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, "add_x5b");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "nop");
    instr(5'd5, 5'd5, 5'd8, 1'b1, 1'b0, "or_issue");
    idle(2'b01, 2'b01, 2'b01, 2'b01, "mem_ex");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");

    // Load-use: lw x9 ; add x10,x9,x1 (held for the replay)
    instr(5'd2, 5'd2, 5'd9, 1'b1, 1'b1, "lw_x9");
    step(1'b1, 5'd9, 5'd1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, "lu_stall");
    instr(5'd9, 5'd1, 5'd10, 1'b1, 1'b0, "lu_replay");
`ifdef HAZ_PERF_CNT_EN
    check_val("stall_cnt_lu", blk_scnt, 32'd1);
    check_val("flush_cnt_lu", blk_fcnt, 32'd0);
`endif
    idle(2'b01, 2'b00, 2'b01, 2'b00, "lu_fwd");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");

    // Double producer: addi x3 ; addi x3 ; add x4,x3,x3
    instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, "addi1");
    instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, "addi2");
    instr(5'd3, 5'd3, 5'd4, 1'b1, 1'b0, "add_x4");
    idle(2'b10, 2'b10, 2'b10, 2'b10, "dbl");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");

    // x0: addi x0,x1 ; add x1,x0,x0
    instr(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, "addi_x0");
    instr(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, "add_x0");
    idle(2'b00, 2'b00, 2'b10, 2'b10, "x0");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");

    // A store never matches as a producer
    instr(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, "sw");
    instr(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, "add_after_sw");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "no_wr");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");

    // Load-use together with a flush: the flush wins and there is no stall
    instr(5'd2, 5'd2, 5'd9, 1'b1, 1'b1, "lw_f");
    step(1'b1, 5'd9, 5'd1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "lf_nostall");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "lf_sel");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");

    // A flush kills the EX entry, so nothing forwards from the killed sub x6
    instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, "add_k");
    step(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "flush_issue");
    instr(5'd6, 5'd6, 5'd7, 1'b1, 1'b0, "flush_kill");
`ifdef HAZ_PERF_CNT_EN
    check_val("stall_cnt_fl", blk_scnt, 32'd1);
    check_val("flush_cnt_fl", blk_fcnt, 32'd2);
`endif
    idle(2'b00, 2'b00, 2'b00, 2'b00, "kill_slot");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");

    // Reset asserted in the hazard cycle
    instr(5'd2, 5'd2, 5'd9, 1'b1, 1'b1, "lw_r");
    step(1'b1, 5'd9, 5'd1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "rst_hz");
    instr(5'd9, 5'd9, 5'd11, 1'b1, 1'b0, "rst_mid");
    check_val("rst_slots_blk", {29'd0, blk_slot[23], blk_slot[15], blk_slot[7]}, 32'd0);
    check_val("rst_slots_nb",  {29'd0, nb_slot[23],  nb_slot[15],  nb_slot[7]},  32'd0);
`ifdef HAZ_PERF_CNT_EN
    check_val("stall_cnt_rst", blk_scnt, 32'd0);
`endif
    idle(2'b00, 2'b00, 2'b00, 2'b00, "rst_next");
    idle(2'b00, 2'b00, 2'b00, 2'b00, "drain");

    // Bounded wait for the monitor to drain the queue
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
